// File: rtl/ro_pair_comparator.sv
// Measurement stage for one ring-oscillator pair of the RO PUF: enables both
// ROs for a fixed gate window, counts synchronized rising edges on each, then
// compares the counts to produce one response bit with a single-cycle Done.
module ro_pair_comparator #(
    parameter int unsigned WINDOW_CYCLES = 1024,
    parameter int unsigned CNT_WIDTH     = 16,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Start,
    input  logic                 RO_a,
    input  logic                 RO_b,
    output logic                 RO_enable,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Response,
    output logic                 Tie,
    output logic                 Saturated,
    output logic [CNT_WIDTH-1:0] Count_a,
    output logic [CNT_WIDTH-1:0] Count_b
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RUN     = 3'd1;
    localparam logic [2:0] ST_SETTLE  = 3'd2;
    localparam logic [2:0] ST_COMPARE = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    // Wide enough for both the gate window and the settle interval.
    localparam int unsigned WIN_W = $clog2(WINDOW_CYCLES + SYNC_STAGES + 2);
    localparam logic [WIN_W-1:0] WIN_LAST    = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SYNC_STAGES);

    logic [2:0]             state_q, state_d;
    logic [WIN_W-1:0]       win_q, win_d;
    logic                   ro_en_q, ro_en_d;
    logic [CNT_WIDTH-1:0]   cnt_a_q, cnt_a_d;
    logic [CNT_WIDTH-1:0]   cnt_b_q, cnt_b_d;
    logic                   resp_q, resp_d;
    logic                   tie_q, tie_d;
    logic                   sat_q, sat_d;

    logic [SYNC_STAGES-1:0] sync_a_q, sync_b_q;
    logic                   edge_a_q, edge_b_q;
    logic                   rise_a, rise_b;

    // Synchronize the asynchronous RO outputs and keep one delayed copy for edge detect.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            sync_a_q <= '0;
            sync_b_q <= '0;
            edge_a_q <= 1'b0;
            edge_b_q <= 1'b0;
        end else begin
            sync_a_q <= {sync_a_q[SYNC_STAGES-2:0], RO_a};
            sync_b_q <= {sync_b_q[SYNC_STAGES-2:0], RO_b};
            edge_a_q <= sync_a_q[SYNC_STAGES-1];
            edge_b_q <= sync_b_q[SYNC_STAGES-1];
        end
    end

    assign rise_a = sync_a_q[SYNC_STAGES-1] & ~edge_a_q;
    assign rise_b = sync_b_q[SYNC_STAGES-1] & ~edge_b_q;

    // Next-state logic: FSM sequencing, window timing, saturating counts, result latch.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        ro_en_d = ro_en_q;
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        resp_d  = resp_q;
        tie_d   = tie_q;
        sat_d   = sat_q;

        // Counting continues through SETTLE to drain edges still in the synchronizer.
        if (state_q == ST_RUN || state_q == ST_SETTLE) begin
            if (rise_a && (cnt_a_q != '1)) cnt_a_d = cnt_a_q + CNT_WIDTH'(1);
            if (rise_b && (cnt_b_q != '1)) cnt_b_d = cnt_b_q + CNT_WIDTH'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    state_d = ST_RUN;
                    win_d   = '0;
                    ro_en_d = 1'b1;
                    cnt_a_d = '0;
                    cnt_b_d = '0;
                end
            end
            ST_RUN: begin
                if (win_q == WIN_LAST) begin
                    state_d = ST_SETTLE;
                    win_d   = '0;
                    ro_en_d = 1'b0;
                end else begin
                    win_d = win_q + WIN_W'(1);
                end
            end
            ST_SETTLE: begin
                if (win_q == SETTLE_LAST) begin
                    state_d = ST_COMPARE;
                    win_d   = '0;
                end else begin
                    win_d = win_q + WIN_W'(1);
                end
            end
            ST_COMPARE: begin
                resp_d  = (cnt_a_q > cnt_b_q);
                tie_d   = (cnt_a_q == cnt_b_q);
                sat_d   = (cnt_a_q == '1) || (cnt_b_q == '1);
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                ro_en_d = 1'b0;
            end
        endcase
    end

    // State registers; async reset aborts any measurement and drops RO_enable at once.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            win_q   <= '0;
            ro_en_q <= 1'b0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            resp_q  <= 1'b0;
            tie_q   <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            ro_en_q <= ro_en_d;
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
            resp_q  <= resp_d;
            tie_q   <= tie_d;
            sat_q   <= sat_d;
        end
    end

    assign RO_enable = ro_en_q;
    assign Busy      = (state_q != ST_IDLE);
    assign Done      = (state_q == ST_DONE);
    assign Response  = resp_q;
    assign Tie       = tie_q;
    assign Saturated = sat_q;
    assign Count_a   = cnt_a_q;
    assign Count_b   = cnt_b_q;

endmodule
